// File: rtl/axis_hdr_pkg.sv
// Shared types and keep/count helpers for the AXI-Stream header extractor.
package axis_hdr_pkg;

    localparam int unsigned DEFAULT_DATA_WIDTH = 32;
    localparam int unsigned MAX_BYTES          = 64;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FIRST = 2'd1,
        BODY  = 2'd2,
        FLUSH = 2'd3
    } state_t;

    // A well-formed keep is contiguous, so its popcount is the byte count.
    function automatic int keep_to_count(input logic [MAX_BYTES-1:0] keep);
        int cnt;
        cnt = 0;
        for (int i = 0; i < int'(MAX_BYTES); i++) begin
            if (keep[i]) cnt++;
        end
        return cnt;
    endfunction

    function automatic logic [MAX_BYTES-1:0] count_to_keep_left(input int cnt, input int nbytes);
        logic [MAX_BYTES-1:0] k;
        k = '0;
        for (int i = 0; i < int'(MAX_BYTES); i++) begin
            k[i] = (i < nbytes) && (i >= nbytes - cnt);
        end
        return k;
    endfunction

    function automatic logic [MAX_BYTES-1:0] count_to_keep_right(input int cnt);
        logic [MAX_BYTES-1:0] k;
        k = '0;
        for (int i = 0; i < int'(MAX_BYTES); i++) begin
            k[i] = (i < cnt);
        end
        return k;
    endfunction

endpackage

// File: rtl/axis_reg_slice.sv
// One-entry registered valid/ready stage; output payload is held while stalled.
module axis_reg_slice #(
    parameter int unsigned WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_s_valid,
    input  logic [WIDTH-1:0] i_s_data,
    output logic             o_s_ready_c,
    output logic             o_m_valid,
    output logic [WIDTH-1:0] o_m_data,
    input  logic             i_m_ready
);

    logic             r_valid;
    logic [WIDTH-1:0] r_data;

    assign o_s_ready_c = !r_valid || i_m_ready;
    assign o_m_valid   = r_valid;
    assign o_m_data    = r_data;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_valid <= 1'b0;
            r_data  <= '0;
        end else if (i_s_valid && o_s_ready_c) begin
            r_valid <= 1'b1;
            r_data  <= i_s_data;
        end else if (i_m_ready) begin
            r_valid <= 1'b0;
        end
    end

endmodule

// File: rtl/axi_stream_extract_header.sv
// Strips a per-frame header from an MSB-first AXI-Stream and re-packs the payload.
// Optional err_short output under AXIS_EXTRACT_HEADER_ERR_EN.
module axi_stream_extract_header
    import axis_hdr_pkg::*;
#(
    parameter int unsigned DATA_WIDTH      = DEFAULT_DATA_WIDTH,
    parameter int unsigned DATA_BYTE_WIDTH = DATA_WIDTH / 8,
    parameter int unsigned BYTE_CNT_WIDTH  = $clog2(DATA_BYTE_WIDTH)
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       valid_in,
    input  logic [DATA_WIDTH-1:0]      data_in,
    input  logic [DATA_BYTE_WIDTH-1:0] keep_in,
    input  logic                       last_in,
    output logic                       ready_in,
    input  logic                       valid_cfg,
    input  logic [BYTE_CNT_WIDTH-1:0]  byte_strip_cnt,
    output logic                       ready_cfg,
    output logic                       valid_hdr,
    output logic [DATA_WIDTH-1:0]      data_hdr,
    output logic [DATA_BYTE_WIDTH-1:0] keep_hdr,
    input  logic                       ready_hdr,
    output logic                       valid_out,
    output logic [DATA_WIDTH-1:0]      data_out,
    output logic [DATA_BYTE_WIDTH-1:0] keep_out,
    output logic                       last_out,
    input  logic                       ready_out
`ifdef AXIS_EXTRACT_HEADER_ERR_EN
    ,
    output logic                       err_short
`endif
);

    localparam int unsigned CW      = BYTE_CNT_WIDTH + 1;
    localparam int unsigned PAY_W   = DATA_WIDTH + DATA_BYTE_WIDTH + 1;
    localparam int unsigned HDR_W   = DATA_WIDTH + DATA_BYTE_WIDTH;
    localparam logic [CW-1:0] DBW_C = CW'(DATA_BYTE_WIDTH);
    localparam logic [CW:0]   DBW_T = (CW+1)'(DATA_BYTE_WIDTH);

    state_t                    r_state, w_state;
    logic [CW-1:0]             r_n, w_n, r_r, w_r, r_flush, w_flush;
    logic [DATA_WIDTH-1:0]     r_res, w_res;
    logic                      r_live;

    logic [DATA_WIDTH-1:0]     w_din;
    logic [CW-1:0]             w_v, w_hcnt;
    logic [CW:0]               w_total;
    logic                      w_short, w_ready_in;
    logic                      w_hdr_valid, w_hdr_rdy;
    logic [DATA_WIDTH-1:0]     w_hdr_data;
    logic [DATA_BYTE_WIDTH-1:0] w_hdr_keep;
    logic                      w_pay_valid, w_pay_rdy, w_pay_last;
    logic [DATA_WIDTH-1:0]     w_pay_data;
    logic [DATA_BYTE_WIDTH-1:0] w_pay_keep;

    assign ready_cfg = (r_state == IDLE) && r_live;
    assign ready_in  = w_ready_in;

    // Bytes outside keep are zeroed so they never leak into residue or header.
    always_comb begin
        w_din = '0;
        for (int b = 0; b < int'(DATA_BYTE_WIDTH); b++) begin
            w_din[b*8 +: 8] = keep_in[b] ? data_in[b*8 +: 8] : 8'h00;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= IDLE;
            r_n     <= '0;
            r_r     <= '0;
            r_flush <= '0;
            r_res   <= '0;
            r_live  <= 1'b0;
        end else begin
            r_state <= w_state;
            r_n     <= w_n;
            r_r     <= w_r;
            r_flush <= w_flush;
            r_res   <= w_res;
            r_live  <= 1'b1;
        end
    end

    always_comb begin
        w_state     = r_state;
        w_n         = r_n;
        w_r         = r_r;
        w_flush     = r_flush;
        w_res       = r_res;
        w_ready_in  = 1'b0;
        w_hdr_valid = 1'b0;
        w_hdr_data  = '0;
        w_hdr_keep  = '0;
        w_pay_valid = 1'b0;
        w_pay_data  = '0;
        w_pay_keep  = '0;
        w_pay_last  = 1'b0;
        w_v         = CW'(keep_to_count(MAX_BYTES'(keep_in)));
        w_short     = 1'b0;
        w_hcnt      = r_n;
        w_total     = {1'b0, r_r} + {1'b0, w_v};
        case (r_state)
            IDLE: begin
                if (ready_cfg && valid_cfg) begin
                    w_n     = CW'(byte_strip_cnt) + CW'(1);
                    w_r     = DBW_C - w_n;
                    w_state = FIRST;
                end
            end
            FIRST: begin
                w_ready_in  = w_hdr_rdy;
                w_hdr_valid = valid_in;
                w_short     = last_in && (w_v < r_n);
                w_hcnt      = w_short ? w_v : r_n;
                w_hdr_data  = w_din >> {DBW_C - w_hcnt, 3'b000};
                w_hdr_keep  = DATA_BYTE_WIDTH'(count_to_keep_right(int'(w_hcnt)));
                if (valid_in && w_hdr_rdy) begin
                    w_res = w_din << {r_n, 3'b000};
                    if (!last_in) begin
                        w_state = BODY;
                    end else if (w_v > r_n) begin
                        w_flush = w_v - r_n;
                        w_state = FLUSH;
                    end else begin
                        w_state = IDLE;
                    end
                end
            end
            BODY: begin
                w_ready_in  = w_pay_rdy;
                w_pay_valid = valid_in;
                w_pay_data  = r_res | (w_din >> {r_r, 3'b000});
                w_pay_keep  = '1;
                if (last_in && (w_total <= DBW_T)) begin
                    w_pay_last = 1'b1;
                    w_pay_keep = DATA_BYTE_WIDTH'(count_to_keep_left(int'(w_total),
                                                                     int'(DATA_BYTE_WIDTH)));
                end
                if (valid_in && w_pay_rdy) begin
                    w_res = w_din << {r_n, 3'b000};
                    if (last_in) begin
                        if (w_total <= DBW_T) begin
                            w_state = IDLE;
                        end else begin
                            w_flush = CW'(w_total - DBW_T);
                            w_state = FLUSH;
                        end
                    end
                end
            end
            FLUSH: begin
                w_pay_valid = 1'b1;
                w_pay_data  = r_res;
                w_pay_keep  = DATA_BYTE_WIDTH'(count_to_keep_left(int'(r_flush),
                                                                  int'(DATA_BYTE_WIDTH)));
                w_pay_last  = 1'b1;
                if (w_pay_rdy) w_state = IDLE;
            end
            default: w_state = IDLE;
        endcase
    end

    axis_reg_slice #(.WIDTH(PAY_W)) u_pay_slice (
        .clk         (clk),
        .rst         (rst),
        .i_s_valid   (w_pay_valid),
        .i_s_data    ({w_pay_data, w_pay_keep, w_pay_last}),
        .o_s_ready_c (w_pay_rdy),
        .o_m_valid   (valid_out),
        .o_m_data    ({data_out, keep_out, last_out}),
        .i_m_ready   (ready_out)
    );

    axis_reg_slice #(.WIDTH(HDR_W)) u_hdr_slice (
        .clk         (clk),
        .rst         (rst),
        .i_s_valid   (w_hdr_valid),
        .i_s_data    ({w_hdr_data, w_hdr_keep}),
        .o_s_ready_c (w_hdr_rdy),
        .o_m_valid   (valid_hdr),
        .o_m_data    ({data_hdr, keep_hdr}),
        .i_m_ready   (ready_hdr)
    );

`ifdef AXIS_EXTRACT_HEADER_ERR_EN
    logic r_err;
    assign err_short = r_err;
    always_ff @(posedge clk or posedge rst) begin
        if (rst) r_err <= 1'b0;
        else     r_err <= (r_state == FIRST) && valid_in && w_hdr_rdy && w_short;
    end
`endif

endmodule

// File: tb/tb_axi_stream_extract_header.sv
// Scoreboard bench for axi_stream_extract_header (32-bit data).
module tb_axi_stream_extract_header;

    logic        clk, rst;
    logic        valid_in, last_in, ready_in;
    logic [31:0] data_in;
    logic [3:0]  keep_in;
    logic        valid_cfg, ready_cfg;
    logic [1:0]  byte_strip_cnt;
    logic        valid_hdr, ready_hdr;
    logic [31:0] data_hdr;
    logic [3:0]  keep_hdr;
    logic        valid_out, last_out, ready_out;
    logic [31:0] data_out;
    logic [3:0]  keep_out;
`ifdef AXIS_EXTRACT_HEADER_ERR_EN
    logic        err_short;
`endif

    axi_stream_extract_header #(.DATA_WIDTH(32)) dut (
        .clk(clk), .rst(rst),
        .valid_in(valid_in), .data_in(data_in), .keep_in(keep_in), .last_in(last_in),
        .ready_in(ready_in),
        .valid_cfg(valid_cfg), .byte_strip_cnt(byte_strip_cnt), .ready_cfg(ready_cfg),
        .valid_hdr(valid_hdr), .data_hdr(data_hdr), .keep_hdr(keep_hdr), .ready_hdr(ready_hdr),
        .valid_out(valid_out), .data_out(data_out), .keep_out(keep_out), .last_out(last_out),
        .ready_out(ready_out)
`ifdef AXIS_EXTRACT_HEADER_ERR_EN
        , .err_short(err_short)
`endif
    );

    int n_tests = 0;
    int n_fail  = 0;
    int exp_err = 0;
    int got_err = 0;
    bit mon_en  = 0;
    bit rnd_mode = 0;

    logic [36:0] exp_out[$];
    logic [35:0] exp_hdr[$];
    logic [31:0] fw[4];

    logic        p_out_stall, p_hdr_stall;
    logic [63:0] p_out, p_hdr;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        assert (got === exp) else begin
            n_fail++;
            $error("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Sink readiness: randomised in random mode, otherwise set by the sequence.
    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (rnd_mode) begin
                ready_out = ($urandom_range(0, 9) < 7);
                ready_hdr = ($urandom_range(0, 9) < 6);
            end
        end
    end

    always @(negedge clk) begin
        if (rst || !mon_en) begin
            p_out_stall = 1'b0;
            p_hdr_stall = 1'b0;
        end else begin
            if (p_out_stall) check("out_hold", {26'd0, valid_out, last_out, keep_out, data_out}, p_out);
            if (p_hdr_stall) check("hdr_hold", {27'd0, valid_hdr, keep_hdr, data_hdr}, p_hdr);
            if (valid_out && ready_out) begin
                check("out_q_nonempty", 64'(exp_out.size() != 0), 64'd1);
                if (exp_out.size() != 0) begin
                    logic [36:0] e;
                    logic [31:0] m;
                    e = exp_out.pop_front();
                    for (int b = 0; b < 4; b++) m[b*8 +: 8] = e[b+1] ? 8'hFF : 8'h00;
                    check("out_data", {32'd0, data_out & m}, {32'd0, e[36:5]});
                    check("out_keep_last", {59'd0, keep_out, last_out}, {59'd0, e[4:0]});
                end
            end
            if (valid_hdr && ready_hdr) begin
                check("hdr_q_nonempty", 64'(exp_hdr.size() != 0), 64'd1);
                if (exp_hdr.size() != 0) begin
                    logic [35:0] h;
                    h = exp_hdr.pop_front();
                    check("hdr_data_keep", {28'd0, data_hdr, keep_hdr}, {28'd0, h});
                end
            end
            p_out_stall = valid_out && !ready_out;
            p_out       = {26'd0, valid_out, last_out, keep_out, data_out};
            p_hdr_stall = valid_hdr && !ready_hdr;
            p_hdr       = {27'd0, valid_hdr, keep_hdr, data_hdr};
        end
    end

`ifdef AXIS_EXTRACT_HEADER_ERR_EN
    always @(negedge clk) if (!rst && err_short) got_err++;
`endif

    task automatic timeout(input string tag);
        n_fail++;
        $display("FAIL %s: timeout waiting for handshake", tag);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $fatal(1, "timeout");
    endtask

    task automatic do_cfg(input int n);
        bit hs;
        int t;
        valid_cfg = 1'b1;
        byte_strip_cnt = 2'(n - 1);
        hs = 0;
        t = 0;
        while (!hs) begin
            @(negedge clk);
            hs = ready_cfg;
            @(posedge clk);
            #1;
            t++;
            if (t > 1000) timeout("cfg");
        end
        valid_cfg = 1'b0;
    endtask

    task automatic send_beat(input logic [31:0] d, input logic [3:0] k, input logic l);
        bit hs;
        int t;
        valid_in = 1'b1;
        data_in  = d;
        keep_in  = k;
        last_in  = l;
        hs = 0;
        t = 0;
        while (!hs) begin
            @(negedge clk);
            hs = ready_in;
            @(posedge clk);
            #1;
            t++;
            if (t > 1000) timeout("beat");
        end
        valid_in = 1'b0;
        last_in  = 1'b0;
    endtask

    // Reference model: header = first min(N,L) bytes, payload = rest packed MSB-first.
    task automatic push_model(input int n, input int nb, input int lastv);
        logic [7:0]  bq[$];
        logic [31:0] hd, wd;
        logic [3:0]  hk, kk;
        int L, h, i;
        for (int b = 0; b < nb; b++)
            for (int k = 0; k < 4; k++)
                if (b < nb - 1 || k < lastv) bq.push_back(fw[b][31-8*k -: 8]);
        L = bq.size();
        h = (n < L) ? n : L;
        hd = '0;
        hk = '0;
        for (int j = 0; j < h; j++) begin
            hd = {hd[23:0], bq[j]};
            hk[j] = 1'b1;
        end
        exp_hdr.push_back({hd, hk});
        i = h;
        while (i < L) begin
            wd = '0;
            kk = '0;
            for (int j = 0; j < 4; j++) begin
                if (i + j < L) begin
                    wd[31-8*j -: 8] = bq[i+j];
                    kk[3-j] = 1'b1;
                end
            end
            exp_out.push_back({wd, kk, (i + 4 >= L)});
            i += 4;
        end
        if (nb == 1 && lastv < n) exp_err++;
    endtask

    task automatic send_frame(input int n, input int nb, input int lastv, input bit gaps);
        do_cfg(n);
        push_model(n, nb, lastv);
        for (int b = 0; b < nb; b++) begin
            if (gaps) repeat ($urandom_range(0, 2)) begin @(posedge clk); #1; end
            send_beat(fw[b], (b == nb - 1) ? 4'(8'hF0 >> lastv) : 4'hF, b == nb - 1);
        end
    endtask

    task automatic wait_drain();
        int t;
        t = 0;
        while (exp_out.size() != 0 || exp_hdr.size() != 0 || valid_out || valid_hdr) begin
            @(posedge clk);
            #1;
            t++;
            if (t > 2000) timeout("drain");
        end
    endtask

    initial begin
        rst = 1'b1;
        valid_in = 0; data_in = '0; keep_in = '0; last_in = 0;
        valid_cfg = 0; byte_strip_cnt = '0;
        ready_hdr = 1'b1; ready_out = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_ready_cfg", {63'd0, ready_cfg}, 64'd0);
        check("rst_valids", {61'd0, valid_out, valid_hdr, last_out}, 64'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        check("rst_ready_in", {63'd0, ready_in}, 64'd0);
        check("rst_out_data", {28'd0, keep_out, data_out}, 64'd0);
        check("rst_hdr_data", {28'd0, keep_hdr, data_hdr}, 64'd0);
        @(posedge clk);
        #1;
        mon_en = 1'b1;

        // N=1, residue flush
        fw[0] = 32'h11223344; fw[1] = 32'h55667788; fw[2] = 32'hAABB0000;
        send_frame(1, 3, 2, 0);
        wait_drain();
        // N=4, header only first beat, pass-through
        fw[0] = 32'hDEADBEEF; fw[1] = 32'h01020304;
        send_frame(4, 2, 4, 0);
        wait_drain();
        // N=3, last keep 1110 gives exactly one full last beat
        fw[0] = 32'hA1A2A3A4; fw[1] = 32'hB1B2B3B4;
        send_frame(3, 2, 3, 0);
        wait_drain();
        // short frame
        fw[0] = 32'h11223344;
        send_frame(4, 1, 2, 0);
        wait_drain();
        // header backpressure across frames
        ready_hdr = 1'b0;
        fw[0] = 32'h0A0B0C0D; fw[1] = 32'h0E0F1011;
        send_frame(2, 2, 4, 0);
        repeat (5) begin @(posedge clk); #1; end
        ready_hdr = 1'b1;
        wait_drain();

        // reset mid-BODY with outputs stalled
        mon_en = 1'b0;
        do_cfg(2);
        send_beat(32'h01234567, 4'hF, 1'b0);
        send_beat(32'h89ABCDEF, 4'hF, 1'b0);
        ready_out = 1'b0;
        ready_hdr = 1'b0;
        @(posedge clk);
        #3;
        rst = 1'b1;
        #1;
        check("midrst_valids", {61'd0, valid_out, valid_hdr, ready_in}, 64'd0);
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        ready_out = 1'b1;
        ready_hdr = 1'b1;
        exp_out.delete();
        exp_hdr.delete();
        @(posedge clk);
        #1;
        mon_en = 1'b1;
        fw[0] = 32'hCAFEF00D; fw[1] = 32'h12345678; fw[2] = 32'h9A000000;
        send_frame(2, 3, 1, 0);
        wait_drain();

        // random traffic
        rnd_mode = 1'b1;
        for (int f = 0; f < 1000; f++) begin
            int nb;
            nb = $urandom_range(1, 4);
            for (int b = 0; b < 4; b++) fw[b] = $urandom;
            send_frame($urandom_range(1, 4), nb, $urandom_range(1, 4), 1);
        end
        wait_drain();
        rnd_mode = 1'b0;
        ready_out = 1'b1;
        ready_hdr = 1'b1;
        repeat (3) begin @(posedge clk); #1; end

        check("final_out_q", 64'(exp_out.size()), 64'd0);
        check("final_hdr_q", 64'(exp_hdr.size()), 64'd0);
`ifdef AXIS_EXTRACT_HEADER_ERR_EN
        check("err_short_count", 64'(got_err), 64'(exp_err));
`endif
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
